// File: rtl/gray_step_counter.sv
// Prescaled up/down binary counter with registered Gray-code mirror.
// Steps once per DIV enabled cycles; synchronous load overrides stepping.
module gray_step_counter #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned TICK_HZ     = 1,
    parameter int unsigned PRE_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_dir,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_bin,
    output logic [WIDTH-1:0] o_gray,
    output logic             o_tick,
    output logic             o_wrap
);

    localparam int unsigned      DIV      = CLK_FREQ_HZ / TICK_HZ;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pre_q,  pre_d;
    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             tick;

    always_comb begin
        // Load takes priority, so a coincident tick is simply dropped.
        tick   = i_en && !i_load && (pre_q == PRE_LAST);
        pre_d  = pre_q;
        bin_d  = bin_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        if (i_load) begin
            pre_d = '0;
            bin_d = i_load_val;
        end else if (i_en) begin
            if (tick) begin
                pre_d  = '0;
                tick_d = 1'b1;
                if (i_dir) begin
                    wrap_d = &bin_q;
                    bin_d  = bin_q + WIDTH'(1);
                end else begin
                    wrap_d = ~|bin_q;
                    bin_d  = bin_q - WIDTH'(1);
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
        // Gray is derived from the next binary value so both registers update together.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_q  <= '0;
            bin_q  <= '0;
            gray_q <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            bin_q  <= bin_d;
            gray_q <= gray_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign o_bin  = bin_q;
    assign o_gray = gray_q;
    assign o_tick = tick_q;
    assign o_wrap = wrap_q;

endmodule

// File: tb/tb_gray_step_counter.sv
// Scoreboard bench for gray_step_counter with WIDTH=4, DIV=4.
// Stimulus pushes expected post-edge state; a monitor pops and compares each cycle.
module tb_gray_step_counter;

    localparam int DIV = 4;

    typedef struct packed {
        logic [3:0] bin;
        logic [3:0] gray;
        logic       tick;
        logic       wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       tick;
    logic       wrap;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_bin = 0;
    int   m_cnt = 0;

    gray_step_counter #(
        .WIDTH      (4),
        .CLK_FREQ_HZ(100),
        .TICK_HZ    (25),
        .PRE_W      (32)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .i_dir     (dir),
        .i_load    (load),
        .i_load_val(load_val),
        .o_bin     (bin),
        .o_gray    (gray),
        .o_tick    (tick),
        .o_wrap    (wrap)
    );

    always #5 clk = ~clk;

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    function automatic int gray2bin(input logic [3:0] g);
        int b = 0;
        for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; the model predicts the state after the next rising edge.
    task automatic step(input logic rst, input logic e, input logic d, input logic ld,
                        input logic [3:0] v);
        exp_t x;
        @(negedge clk);
        rst_n    = rst;
        en       = e;
        dir      = d;
        load     = ld;
        load_val = v;
        x.tick   = 1'b0;
        x.wrap   = 1'b0;
        if (!rst) begin
            m_bin = 0;
            m_cnt = 0;
        end else if (ld) begin
            m_bin = int'(v);
            m_cnt = 0;
        end else if (e) begin
            m_cnt++;
            if (m_cnt == DIV) begin
                m_cnt  = 0;
                x.tick = 1'b1;
                x.wrap = d ? (m_bin == 15) : (m_bin == 0);
                m_bin  = d ? (m_bin + 1) % 16 : (m_bin + 15) % 16;
            end
        end
        x.bin  = 4'(m_bin);
        x.gray = 4'(to_gray(m_bin));
        sb_q.push_back(x);
    endtask

    task automatic async_reset_check();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        m_bin = 0;
        m_cnt = 0;
        #1;
        check("async_rst_bin", int'(bin), 0);
        check("async_rst_gray", int'(gray), 0);
        check("async_rst_tick", int'(tick), 0);
        check("async_rst_wrap", int'(wrap), 0);
    endtask

    // Monitor: compares every scored cycle plus Gray-code properties.
    initial begin : monitor
        exp_t       e;
        logic [3:0] prev_gray = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("bin", int'(bin), int'(e.bin));
                check("gray", int'(gray), int'(e.gray));
                check("tick", int'(tick), int'(e.tick));
                check("wrap", int'(wrap), int'(e.wrap));
                check("gray_decode", gray2bin(gray), int'(bin));
                if (tick) check("gray_one_bit", $countones(gray ^ prev_gray), 1);
            end
            prev_gray = gray;
        end
    end

    initial begin : stim
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

        // Full up sweep through wrap.
        repeat (16 * DIV) step(1'b1, 1'b1, 1'b1, 1'b0, 4'(7));
        // Down through wrap: 15, 14, 13.
        repeat (3 * DIV) step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

        // Load on the cycle a tick would fire.
        for (int i = 0; i < 8 && m_cnt != DIV - 1; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd9);
        repeat (DIV) step(1'b1, 1'b1, 1'b1, 1'b0, 4'd3);

        // Freeze at prescaler 2 with count 5; load also works with enable low.
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'd5);
        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);

        // Asynchronous reset mid-period at count 12.
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd12);
        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        async_reset_check();
        repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        repeat (DIV + 2) step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            step(1'b1, ($urandom_range(0, 9) < 8), 1'($urandom), ($urandom_range(0, 19) == 0),
                 4'($urandom));
        end

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        check("scoreboard_drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
